sa_input_skew: RTL and testbench
================================

# sa_input_skew

Diagonal skew stage between the im2col input unit and the systolic array. Each cycle it accepts one 9-lane vector of signed 8-bit activations and delays lane k by k extra cycles, so the array sees the wavefront ordering it needs. It tracks the stream from start to last vector, drains the delay lines, and signals completion to the array controller.

## Interface
- LANES, 9, number of activation lanes (im2col kernel positions)
- DATA_W, 8, signed activation width
- CNT_W, 16, width of the accepted-vector counter
- i_clk  in  1  single clock
- i_rst  in  1  reset; synchronous and active-high, one clock
- i_start  in  1  stream start pulse (driven by im2col started_o)
- i_valid  in  1  i_data carries a valid vector this cycle
- i_data  in  LANES x DATA_W signed  im2col output vector, lane index = kernel position
- i_last  in  1  upstream finished (im2col finished_send); level or pulse
- o_data  out  LANES x DATA_W signed  skewed lanes to systolic array row inputs
- o_valid  out  LANES  per-lane valid, skewed identically to o_data
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle pulse when the last skewed data has left lane LANES-1
- o_vec_count  out  CNT_W  vectors accepted in the current or last stream

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: i_start -> STREAM, clear o_vec_count and all delay lines. i_valid/i_last ignored in IDLE.
- STREAM: i_valid=1 -> capture i_data into lane stage 0 with valid=1, o_vec_count+1 (saturates at all-ones). i_valid=0 -> insert zero data, valid=0 (bubble preserved through skew).
- i_last seen in STREAM -> DRAIN; a vector with i_valid=1 in the same cycle as i_last is accepted.
- DRAIN: inputs treated as bubbles; counter of LANES cycles; on expiry -> DONE.
- DONE: o_done=1 for exactly one cycle -> IDLE. o_vec_count holds until next start.
- i_start while o_busy=1: ignored. i_start and i_last same cycle in IDLE: start taken, last ignored.
- i_last with zero accepted vectors: drain still runs, o_done pulses, o_vec_count=0.
- Invalid lanes drive o_data=0 (never stale data).

## Timing
- Lane k: o_data[k]/o_valid[k] = vector sampled k+1 cycles earlier (lane 0 one-register latency, lane 8 nine cycles).
- Last vector accepted at cycle T: lane LANES-1 emits it at T+LANES; o_done high at T+LANES+1.
- i_last at cycle T -> state DRAIN from T+1; o_busy falls with o_done's cycle ending (low at T+LANES+2).
- Reset (any state, including mid-stream): next cycle state IDLE, o_data all zero, o_valid=0, o_busy=0, o_done=0, o_vec_count=0, delay lines zero.
- No backpressure: array consumes every cycle.

## Structure
- cvxif_pkg additions: SA_LANES=9, SA_DATA_W=8 constants; typedef enum skew_state_e {IDLE, STREAM, DRAIN, DONE}; typedef logic signed [SA_DATA_W-1:0] sa_act_t.
- Sub-module skew_delay_line (parameter DEPTH, DATA_W): shift register of data+valid, synchronous clear; instantiated per lane via generate with DEPTH=k+1.
- Top holds FSM, drain counter (ceil(log2(LANES+1)) bits), vector counter.

## Test plan
- Reset then start, 3 valid vectors lane k = 10*v+k (v=1..3), i_last with v3 -> lane 0 emits 10,20,30 at T+1..; lane 8 emits 18,28,38 starting 9 cycles after v1; o_done 10 cycles after v3; o_vec_count=3.
- Bubble: valid, invalid, valid -> every lane shows valid,0-invalid,valid at its skewed offset; count=2.
- i_last with no valid vectors -> o_done after LANES+1 cycles, count=0, all o_valid stay 0.
- i_start mid-stream and i_valid in IDLE -> no effect on count or outputs.
- i_rst asserted mid-DRAIN -> next cycle all outputs zero, IDLE; no o_done pulse; new start works normally.
- 65540 valid vectors -> o_vec_count saturates at 0xFFFF.

Source files
------------

// File: rtl/sa_input_skew_pkg.sv
// Shared constants and types for the systolic-array input skew stage.
package sa_input_skew_pkg;

  localparam int SA_LANES  = 9;
  localparam int SA_DATA_W = 8;
  localparam int SA_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } skew_state_e;

  typedef logic signed [SA_DATA_W-1:0] sa_act_t;

  // Drain counter must be able to hold the value LANES.
  function automatic int drain_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/sa_input_skew_delay_line.sv
// Fixed-depth shift register carrying one activation lane plus its valid bit.
// Bubbles are stored as zero data so an invalid slot never shows stale values.
module sa_input_skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      r_data[0]  <= i_valid ? i_data : '0;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/sa_input_skew.sv
// Diagonal skew stage: lane k of each accepted vector is delayed k+1 cycles,
// then the delay lines are drained and completion is signalled with o_done.
module sa_input_skew
  import sa_input_skew_pkg::*;
#(
  parameter int LANES  = SA_LANES,
  parameter int DATA_W = SA_DATA_W,
  parameter int CNT_W  = SA_CNT_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic [LANES*DATA_W-1:0] i_data,
  input  logic                    i_last,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic [LANES-1:0]        o_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CNT_W-1:0]        o_vec_count
);

  localparam int DRAIN_W = drain_cnt_w(LANES);

  skew_state_e        r_state;
  skew_state_e        w_state_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0]   r_vec_count;
  logic               w_clear;
  logic               w_accept;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = STREAM;
          w_clear      = 1'b1;
        end
      end
      STREAM: begin
        w_accept = i_valid;
        if (i_last) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == DRAIN_W'(LANES - 1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counts the LANES cycles needed for the deepest lane to empty.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != DRAIN) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) begin
      r_vec_count <= '0;
    end else if (w_accept && r_vec_count != {CNT_W{1'b1}}) begin
      r_vec_count <= r_vec_count + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      sa_input_skew_delay_line #(
        .DEPTH  (gi + 1),
        .DATA_W (DATA_W)
      ) u_line (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clear),
        .i_valid (w_accept),
        .i_data  (i_data[gi*DATA_W +: DATA_W]),
        .o_data  (o_data[gi*DATA_W +: DATA_W]),
        .o_valid (o_valid[gi])
      );
    end
  endgenerate

  assign o_busy      = (r_state != IDLE);
  assign o_vec_count = r_vec_count;

endmodule

// File: tb/tb_sa_input_skew.sv
// Bench for sa_input_skew: directed table, corner-case sequences and random
// traffic, all checked every cycle against a cycle-history reference model.
module tb_sa_input_skew;

  localparam int LANES = 9;
  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int VW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst, start, valid, last;
  logic [VW-1:0] data;
  logic [VW-1:0] o_data;
  logic [LANES-1:0] o_valid;
  logic          o_busy, o_done;
  logic [CW-1:0] o_vec_count;

  always #5 clk = ~clk;

  sa_input_skew #(.LANES(LANES), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_valid     (valid),
    .i_data      (data),
    .i_last      (last),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_vec_count (o_vec_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: history of what was taken in on each edge, newest first.
  bit            m_busy, m_stream;
  int            m_cnt, m_done_edge, edge_n;
  bit            h_v [LANES];
  logic [VW-1:0] h_d [LANES];

  typedef struct {
    bit   s, v, l;
    int   vec;
    int   ev, l0, l8;
    bit   eb, ed;
    int   ec;
  } row_t;
  row_t tbl [14];

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input int v);
    logic [VW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*DW +: DW] = 8'(10 * v + k);
    return d;
  endfunction

  task automatic model_clear_hist();
    for (int k = 0; k < LANES; k++) begin
      h_v[k] = 1'b0;
      h_d[k] = '0;
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v, input bit l,
                            input logic [VW-1:0] d);
    bit acc;
    acc = 1'b0;
    edge_n++;
    if (r) begin
      m_busy = 0; m_stream = 0; m_cnt = 0; m_done_edge = -100;
      model_clear_hist();
    end else begin
      if (!m_busy) begin
        if (s) begin
          m_busy = 1; m_stream = 1; m_cnt = 0;
          model_clear_hist();
        end
      end else if (m_stream) begin
        acc = v;
        if (v && m_cnt < 65535) m_cnt++;
        if (l) begin
          m_stream    = 0;
          m_done_edge = edge_n + LANES;
        end
      end else if (edge_n == m_done_edge + 1) begin
        m_busy = 0;
      end
      for (int k = LANES - 1; k > 0; k--) begin
        h_v[k] = h_v[k-1];
        h_d[k] = h_d[k-1];
      end
      h_v[0] = acc;
      h_d[0] = acc ? d : '0;
    end
  endtask

  task automatic tick(input bit r, input bit s, input bit v, input bit l,
                      input logic [VW-1:0] d);
    logic [VW-1:0]    exp_d;
    logic [LANES-1:0] exp_v;
    rst = r; start = s; valid = v; last = l; data = d;
    @(posedge clk);
    model_edge(r, s, v, l, d);
    #1;
    for (int k = 0; k < LANES; k++) begin
      exp_v[k]          = h_v[k];
      exp_d[k*DW +: DW] = h_v[k] ? h_d[k][k*DW +: DW] : 8'h00;
    end
    chki("valid", int'(o_valid), int'(exp_v));
    chkd("data", o_data, exp_d);
    chki("busy", int'(o_busy), int'(m_busy));
    chki("done", int'(o_done), int'(m_busy && !m_stream && edge_n == m_done_edge));
    chki("count", int'(o_vec_count), m_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, '0);
  endtask

  task automatic set_row(input int i, input bit s, input bit v, input bit l, input int vec,
                         input int ev, input int l0, input int l8,
                         input bit eb, input bit ed, input int ec);
    tbl[i].s = s; tbl[i].v = v; tbl[i].l = l; tbl[i].vec = vec;
    tbl[i].ev = ev; tbl[i].l0 = l0; tbl[i].l8 = l8;
    tbl[i].eb = eb; tbl[i].ed = ed; tbl[i].ec = ec;
  endtask

  initial begin
    int            n, dones, seen, any_v;
    logic [95:0]   rnd;

    rst = 1; start = 0; valid = 0; last = 0; data = '0;
    edge_n = 0; m_busy = 0; m_stream = 0; m_cnt = 0; m_done_edge = -100;
    model_clear_hist();

    // Three vectors, last with v3: lane 0 shows 10/20/30, lane 8 shows 18/28/38.
    set_row(0,  1, 0, 0, 0, 'h000,  0,  0, 1, 0, 0);
    set_row(1,  0, 1, 0, 1, 'h001, 10,  0, 1, 0, 1);
    set_row(2,  0, 1, 0, 2, 'h003, 20,  0, 1, 0, 2);
    set_row(3,  0, 1, 1, 3, 'h007, 30,  0, 1, 0, 3);
    set_row(4,  0, 0, 0, 0, 'h00E,  0,  0, 1, 0, 3);
    set_row(5,  0, 0, 0, 0, 'h01C,  0,  0, 1, 0, 3);
    set_row(6,  0, 0, 0, 0, 'h038,  0,  0, 1, 0, 3);
    set_row(7,  0, 0, 0, 0, 'h070,  0,  0, 1, 0, 3);
    set_row(8,  0, 0, 0, 0, 'h0E0,  0,  0, 1, 0, 3);
    set_row(9,  0, 0, 0, 0, 'h1C0,  0, 18, 1, 0, 3);
    set_row(10, 0, 0, 0, 0, 'h180,  0, 28, 1, 0, 3);
    set_row(11, 0, 0, 0, 0, 'h100,  0, 38, 1, 0, 3);
    set_row(12, 0, 0, 0, 0, 'h000,  0,  0, 1, 1, 3);
    set_row(13, 0, 0, 0, 0, 'h000,  0,  0, 0, 0, 3);

    tick(1, 0, 0, 0, '0);
    tick(1, 1, 1, 0, mkvec(5));
    chki("rst_busy", int'(o_busy), 0);
    chki("rst_valid", int'(o_valid), 0);
    chki("rst_count", int'(o_vec_count), 0);
    chkd("rst_data", o_data, '0);

    for (int i = 0; i < 14; i++) begin
      tick(0, tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].v ? mkvec(tbl[i].vec) : '0);
      chki("tbl_valid", int'(o_valid), tbl[i].ev);
      chki("tbl_lane0", int'(o_data[DW-1:0]), tbl[i].l0);
      chki("tbl_lane8", int'(o_data[VW-1:VW-DW]), tbl[i].l8);
      chki("tbl_busy", int'(o_busy), int'(tbl[i].eb));
      chki("tbl_done", int'(o_done), int'(tbl[i].ed));
      chki("tbl_count", int'(o_vec_count), tbl[i].ec);
    end

    // Bubble between two valid vectors must travel through every lane.
    tick(0, 1, 0, 0, '0);
    tick(0, 0, 1, 0, mkvec(4));
    tick(0, 0, 0, 0, mkvec(9));
    tick(0, 0, 1, 1, mkvec(6));
    idle(12);
    chki("bubble_count", int'(o_vec_count), 2);

    // Last with no vectors: done after LANES+1 cycles, nothing valid, count 0.
    tick(0, 1, 0, 1, '0);
    tick(0, 0, 0, 1, '0);
    seen = 0; any_v = 0; n = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      tick(0, 0, 0, 0, '0);
      any_v = any_v | int'(|o_valid);
      if (o_done) begin seen = 1; n = i; end
    end
    chki("empty_done_latency", n + 1, LANES + 1);
    chki("empty_any_valid", any_v, 0);
    chki("empty_count", int'(o_vec_count), 0);
    idle(2);

    // Start while busy is ignored; valid in IDLE is ignored.
    tick(0, 1, 0, 0, '0);
    tick(0, 0, 1, 0, mkvec(2));
    tick(0, 1, 1, 0, mkvec(3));
    tick(0, 0, 0, 1, '0);
    idle(11);
    tick(0, 0, 1, 0, mkvec(7));
    tick(0, 0, 1, 1, mkvec(8));
    chki("ignore_count", int'(o_vec_count), 2);
    chki("ignore_valid", int'(o_valid), 0);

    // Reset in the middle of the drain.
    tick(0, 1, 0, 0, '0);
    tick(0, 0, 1, 0, mkvec(1));
    tick(0, 0, 1, 1, mkvec(2));
    idle(4);
    tick(1, 0, 0, 0, '0);
    chki("mid_rst_busy", int'(o_busy), 0);
    chki("mid_rst_valid", int'(o_valid), 0);
    chkd("mid_rst_data", o_data, '0);
    chki("mid_rst_count", int'(o_vec_count), 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0, '0);
      if (o_done) dones++;
    end
    chki("mid_rst_no_done", dones, 0);
    tick(0, 1, 0, 0, '0);
    tick(0, 0, 1, 1, mkvec(3));
    seen = 0;
    for (int i = 0; i < 15 && seen == 0; i++) begin
      tick(0, 0, 0, 0, '0);
      if (o_done) seen = 1;
    end
    chki("restart_done_seen", seen, 1);
    chki("restart_count", int'(o_vec_count), 1);
    idle(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, rnd[VW-1:0]);
    end
    tick(1, 0, 0, 0, '0);

    // Counter saturation.
    tick(0, 1, 0, 0, '0);
    for (int i = 0; i < 65540; i++) tick(0, 0, 1, 0, mkvec(i % 12));
    tick(0, 0, 0, 1, '0);
    chki("sat_count", int'(o_vec_count), 'hFFFF);
    idle(12);
    chki("sat_idle_busy", int'(o_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
